// File: rtl/comparator_serial_msb_pkg.sv
// +----------------------------------------------------------------------+
// | comparator_serial_pkg - shared types for the serial MSB comparator   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package comparator_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef enum logic [1:0] {
    RES_GT = 2'd0,
    RES_EQ = 2'd1,
    RES_LT = 2'd2
  } cmp_res_t;

  // One-hot {gt, eq, lt}
  function automatic logic [2:0] res_to_flags(input cmp_res_t r);
    case (r)
      RES_GT:  return 3'b100;
      RES_EQ:  return 3'b010;
      RES_LT:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_serial_msb_cmp2.sv
// +----------------------------------------------------------------------+
// | cmp2_digit - combinational 2-bit unsigned digit comparator           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module cmp2_digit (
  input  logic [1:0] da,
  input  logic [1:0] db,
  output logic       dgt,
  output logic       deq,
  output logic       dlt
);

  assign dgt = (da > db);
  assign deq = (da == db);
  assign dlt = (da < db);

endmodule

`default_nettype wire

// File: rtl/comparator_serial_msb.sv
// +----------------------------------------------------------------------+
// | comparator_serial_msb - serial MSB-first magnitude comparator;       |
// | define EARLY_EXIT_EN to finish on the first differing digit. Rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module comparator_serial_msb
  import comparator_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NDIG = WIDTH / 2;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("comparator_serial_msb: WIDTH must be even and >= 2");
  end

  cmp_state_t      state_q, state_d;
  cmp_res_t        res_q, res_d;
  logic [IDXW-1:0] idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]      flags_q;
  logic            valid_q;
  logic [1:0]      da, db;
  logic            dgt, deq, dlt;
  logic            accept, run_last, differ;

  assign da = a_q[{idx_q, 1'b0} +: 2];
  assign db = b_q[{idx_q, 1'b0} +: 2];

  cmp2_digit u_digit (
    .da  (da),
    .db  (db),
    .dgt (dgt),
    .deq (deq),
    .dlt (dlt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (run_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready = (state_q == IDLE);
    accept   = in_valid && (state_q == IDLE);
    differ   = (res_q == RES_EQ) && !deq;
`ifdef EARLY_EXIT_EN
    run_last = (state_q == RUN) && ((idx_q == '0) || differ);
`else
    run_last = (state_q == RUN) && (idx_q == '0);
`endif
    // Running result freezes on the first unequal digit
    res_d = res_q;
    if (state_q == RUN && res_q == RES_EQ) begin
      case ({dgt, deq, dlt})
        3'b100:  res_d = RES_GT;
        3'b001:  res_d = RES_LT;
        default: res_d = res_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
      res_q <= RES_EQ;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      idx_q <= IDXW'(NDIG - 1);
      res_q <= RES_EQ;
    end else if (state_q == RUN) begin
      res_q <= res_d;
      if (idx_q != '0) idx_q <= idx_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      flags_q <= 3'b000;
    end else if (run_last) begin
      valid_q <= 1'b1;
      flags_q <= res_to_flags(res_d);
    end else if (state_q == DONE && out_ready) begin
      valid_q <= 1'b0;
      flags_q <= 3'b000;
    end
  end

  assign out_valid    = valid_q;
  assign {gt, eq, lt} = flags_q;

endmodule

`default_nettype wire
